subckt_pattern_driver: RTL

Pattern-driving and response-capture block for the extracted netlist subcircuits in the trojan-detection benchmark set. It generates pseudo-random input vectors with an LFSR and drives them into a single-output subcircuit under test. It samples that subcircuit's output after a fixed pipeline latency and compacts the responses into a MISR signature. It is the stimulus/observe end that pairs with every `test_I*` node subcircuit, and runs one complete test session per `start_i` pulse.

---
 rtl/subckt_pattern_driver.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/subckt_pattern_driver.sv
// subckt_pattern_driver
//
// Stimulus/observe end for a single-output netlist subcircuit. One session per
// start_i: an LFSR issues N_PATTERNS pseudo-random vectors, one per cycle, and
// the subcircuit's response to each is folded into a 16-bit MISR exactly LAT
// cycles after its pattern was valid.
//
// Parameters:
//   N_IN        pattern width (1..16)
//   N_PATTERNS  patterns per session (0..65535)
//   LAT         cycles from pattern-valid cycle to response sample (1..8)
//   SEED        LFSR start value; 16'h0000 is replaced by 16'h0001
//
// Ports:
//   I1470_clk    in   clock, rising edge
//   I1477_rst    in   synchronous active-high reset
//   start_i      in   session start, honoured only in IDLE or DONE
//   pat_o        out  pattern to the subcircuit (0 outside RUN)
//   pat_valid_o  out  pat_o carries a live pattern
//   resp_i       in   subcircuit output
//   signature_o  out  MISR contents
//   count_o      out  responses captured this session
//   busy_o       out  session in RUN or DRAIN
//   done_o       out  session complete, signature/count final
//   golden_i     in   expected signature      (SUBCKT_DRV_GOLDEN_CMP_EN only)
//   mismatch_o   out  signature != golden_i   (SUBCKT_DRV_GOLDEN_CMP_EN only)
//
// Build option: define SUBCKT_DRV_GOLDEN_CMP_EN to add the golden-signature
// comparator and its two ports; the default build has neither.
//
// state   | meaning
// S_IDLE  | after reset, waiting for start_i
// S_RUN   | issuing one LFSR pattern per cycle
// S_DRAIN | all patterns issued, waiting LAT cycles for the last response
// S_DONE  | signature and count final; start_i begins a new session

module subckt_pattern_driver #(
   parameter int          N_IN       = 4,
   parameter int          N_PATTERNS = 1000,
   parameter int          LAT        = 1,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic            I1470_clk,
   input  logic            I1477_rst,
   input  logic            start_i,
   output logic [N_IN-1:0] pat_o,
   output logic            pat_valid_o,
   input  logic            resp_i,
   output logic [15:0]     signature_o,
   output logic [15:0]     count_o,
   output logic            busy_o,
   output logic            done_o
`ifdef SUBCKT_DRV_GOLDEN_CMP_EN
   ,
   input  logic [15:0]     golden_i,
   output logic            mismatch_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] PAT_LOAD   = (N_PATTERNS > 0) ? 16'(N_PATTERNS - 1) : 16'h0000;
   localparam logic [3:0]  DRAIN_LOAD = 4'(LAT - 1);
   localparam bit          NO_PATS    = (N_PATTERNS == 0);

   // Shared by the LFSR and the MISR: x^16+x^14+x^13+x^11+1, shift toward MSB.
   function automatic logic [15:0] shift16(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   state_t          state_q;
   logic [15:0]     lfsr_q;
   logic [15:0]     lfsr_d;
   logic [15:0]     pat_cnt_q;
   logic [3:0]      drain_cnt_q;
   logic [N_IN-1:0] pat_q;
   logic            pat_valid_q;
   logic            busy_q;
   logic            done_q;
   logic [LAT-1:0]  vld_sr_q;
   logic [LAT-1:0]  vld_sr_d;
   logic [15:0]     misr_q;
   logic [15:0]     misr_d;
   logic [15:0]     count_q;
   logic [15:0]     count_d;
   logic            start_ok;
   logic            capture;
   logic            enter_done;

   // vld_sr delays pat_valid by LAT cycles; its last stage marks the cycle
   // whose closing edge samples the matching response.
   always_comb begin
      start_ok   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
      capture    = vld_sr_q[LAT-1];
      enter_done = (start_ok && NO_PATS) ||
                   ((state_q == S_DRAIN) && (drain_cnt_q == 4'd0));
      lfsr_d     = shift16(lfsr_q);

      vld_sr_d    = '0;
      vld_sr_d[0] = pat_valid_q;
      for (int i = 1; i < LAT; i++) begin
         vld_sr_d[i] = vld_sr_q[i-1];
      end

      misr_d  = misr_q;
      count_d = count_q;
      if (start_ok) begin
         misr_d  = 16'h0000;
         count_d = 16'h0000;
      end else if (capture) begin
         misr_d  = shift16(misr_q) ^ {15'b0, resp_i};
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         state_q     <= S_IDLE;
         lfsr_q      <= SEED_EFF;
         pat_cnt_q   <= 16'h0000;
         drain_cnt_q <= 4'd0;
         pat_q       <= '0;
         pat_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  lfsr_q <= SEED_EFF;
                  if (NO_PATS) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= S_RUN;
                     pat_q       <= SEED_EFF[N_IN-1:0];
                     pat_valid_q <= 1'b1;
                     pat_cnt_q   <= PAT_LOAD;
                     busy_q      <= 1'b1;
                     done_q      <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               lfsr_q <= lfsr_d;
               if (pat_cnt_q == 16'h0000) begin
                  state_q     <= S_DRAIN;
                  pat_q       <= '0;
                  pat_valid_q <= 1'b0;
                  drain_cnt_q <= DRAIN_LOAD;
               end else begin
                  pat_cnt_q <= pat_cnt_q - 16'd1;
                  pat_q     <= lfsr_d[N_IN-1:0];
               end
            end
            S_DRAIN: begin
               // Terminal count lines up with the capture edge of the last response.
               if (drain_cnt_q == 4'd0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q - 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         vld_sr_q <= '0;
         misr_q   <= 16'h0000;
         count_q  <= 16'h0000;
      end else begin
         vld_sr_q <= vld_sr_d;
         misr_q   <= misr_d;
         count_q  <= count_d;
      end
   end

`ifdef SUBCKT_DRV_GOLDEN_CMP_EN
   logic mismatch_q;

   // Compare against misr_d so the final capture on the DONE-entry edge counts.
   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         mismatch_q <= 1'b0;
      end else if (enter_done) begin
         mismatch_q <= (misr_d != golden_i);
      end else if (start_ok) begin
         mismatch_q <= 1'b0;
      end
   end

   assign mismatch_o = mismatch_q;
`endif

   assign pat_o       = pat_q;
   assign pat_valid_o = pat_valid_q;
   assign signature_o = misr_q;
   assign count_o     = count_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
